// File: rtl/decoder_2x4.sv
// Registered 2-to-4 one-hot decoder with decode enable and a valid flag.
// All outputs come straight from flops; reset is synchronous and active-low.
module decoder_2x4 (
    input  logic A,
    input  logic B,
    output logic O1,
    output logic O2,
    output logic O3,
    output logic O4,
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic valid
);

    logic [1:0] sel;
    logic [3:0] dec_d;
    logic [3:0] dec_q;
    logic       valid_d;
    logic       valid_q;

    assign sel = {A, B};

    // Bit i of the decode vector goes high when the select equals i and decode is enabled.
    always_comb begin
        dec_d   = '0;
        valid_d = en;
        for (int i = 0; i < 4; i++) begin
            dec_d[i] = en && (sel == i[1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dec_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            dec_q   <= dec_d;
            valid_q <= valid_d;
        end
    end

    assign O1    = dec_q[0];
    assign O2    = dec_q[1];
    assign O3    = dec_q[2];
    assign O4    = dec_q[3];
    assign valid = valid_q;

endmodule

// File: tb/tb_decoder_2x4.sv
// Bench for decoder_2x4: directed vector table, a hand-written reset sequence,
// and randomized traffic checked against a select-to-one-hot reference model.
module tb_decoder_2x4;

    logic clk;
    logic rst_n;
    logic a;
    logic b;
    logic en;
    logic o1, o2, o3, o4;
    logic valid;

    int vectors;
    int miscompares;

    decoder_2x4 dut (
        .A     (a),
        .B     (b),
        .O1    (o1),
        .O2    (o2),
        .O3    (o3),
        .O4    (o4),
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       en;
        logic       a;
        logic       b;
        logic [3:0] exp_o;
        logic       exp_v;
    } vec_t;

    vec_t tbl[$];

    // Drive inputs at a falling edge, let the rising edge capture them,
    // then compare at the following falling edge.
    task automatic apply(input string name, input logic r, input logic e,
                         input logic ia, input logic ib,
                         input logic [3:0] exp_o, input logic exp_v);
        logic [3:0] got_o;
        rst_n = r;
        en    = e;
        a     = ia;
        b     = ib;
        @(negedge clk);
        got_o = {o4, o3, o2, o1};
        vectors++;
        if (got_o !== exp_o || valid !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got O4..O1=%b valid=%b, expected O4..O1=%b valid=%b",
                     name, got_o, valid, exp_o, exp_v);
        end else begin
            $display("ok   %s: rst_n=%b en=%b AB=%b%b -> O4..O1=%b valid=%b",
                     name, r, e, ia, ib, got_o, valid);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        a     = 1'b0;
        b     = 1'b0;

        // reset hold with en=1, AB=11
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0});
        // exhaustive decode
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1});
        // enable gating: outputs cleared, not held
        tbl.push_back('{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1});
        // reset mid-stream, then release straight into decode
        tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 4'b0000, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1});
        // back-to-back alternation with no all-zero gap
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1});
            else            tbl.push_back('{1'b1, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1});
        end

        @(negedge clk);
        foreach (tbl[i]) begin
            apply($sformatf("table[%0d]", i), tbl[i].rst_n, tbl[i].en,
                  tbl[i].a, tbl[i].b, tbl[i].exp_o, tbl[i].exp_v);
        end

        // Hand sequence: reset with en=0 must beat a following decode only for its own edge.
        apply("seq_rst_en0",   1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0);
        apply("seq_release10", 1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1);
        apply("seq_reset_ab00", 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        apply("seq_release00", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0001, 1'b1);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 1000; n++) begin
            logic       r_r, r_e, r_a, r_b;
            logic [3:0] m_o;
            logic       m_v;
            int         sel_val;
            r_r = ($urandom_range(0, 31) != 0);
            r_e = ($urandom_range(0, 3) != 0);
            r_a = 1'($urandom_range(0, 1));
            r_b = 1'($urandom_range(0, 1));
            sel_val = 2 * int'(r_a) + int'(r_b);
            if (r_r && r_e) begin
                m_o = 4'(1 << sel_val);
                m_v = 1'b1;
            end else begin
                m_o = 4'b0000;
                m_v = 1'b0;
            end
            apply($sformatf("rand[%0d]", n), r_r, r_e, r_a, r_b, m_o, m_v);
            if (r_r && r_e) begin
                vectors++;
                if ($countones({o4, o3, o2, o1}) != 1) begin
                    miscompares++;
                    $display("FAIL onehot[%0d]: got popcount=%0d, expected 1",
                             n, $countones({o4, o3, o2, o1}));
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
